// File: rtl/ring_route_engine.sv
// ============================================================================
// Module   : ring_route_engine
// Purpose  : Next-hop lookup for one router on a bidirectional ring. Each
//            destination maps to a next-hop router through a NUM_ROUTERS-entry
//            table whose default sends traffic along the shorter direction,
//            with ties going clockwise. Lookup latency is one cycle, through
//            a single valid/ready output register.
// Macro    : ROUTE_TABLE_WR_EN - when defined, the table is held in registers
//            and can be rewritten through cfg_wr_* or reloaded with
//            cfg_restore. When undefined, the table is constant defaults and
//            the cfg_* inputs are ignored.
// Ports    : clk, rst_n (asynchronous, active-low)
//            req_valid / req_ready / req_dst            - lookup request
//            rsp_valid / rsp_ready / rsp_next /
//            rsp_local / rsp_err                        - lookup result
//            cfg_wr_en / cfg_wr_idx / cfg_wr_next /
//            cfg_restore                                - table programming
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_route_engine #(
  parameter int NUM_ROUTERS  = 4,
  parameter int ROUTER_WIDTH = 2,
  parameter int ROUTER_ID    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ROUTER_WIDTH-1:0] req_dst,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ROUTER_WIDTH-1:0] rsp_next,
  output logic                    rsp_local,
  output logic                    rsp_err,
  input  logic                    cfg_wr_en,
  input  logic [ROUTER_WIDTH-1:0] cfg_wr_idx,
  input  logic [ROUTER_WIDTH-1:0] cfg_wr_next,
  input  logic                    cfg_restore
);

  // One extra bit so that NUM_ROUTERS == 2**ROUTER_WIDTH is representable.
  localparam logic [ROUTER_WIDTH:0]   NUM_EXT = (ROUTER_WIDTH+1)'(NUM_ROUTERS);
  localparam logic [ROUTER_WIDTH-1:0] SELF_ID = ROUTER_WIDTH'(ROUTER_ID);

  // Default next hop: clockwise neighbour when the clockwise distance is at
  // most half the ring, otherwise the counter-clockwise neighbour.
  function automatic logic [ROUTER_WIDTH-1:0] default_hop(input int dst);
    int cw;
    if (dst == ROUTER_ID) return SELF_ID;
    cw = (dst - ROUTER_ID + NUM_ROUTERS) % NUM_ROUTERS;
    if (cw <= NUM_ROUTERS / 2) return ROUTER_WIDTH'((ROUTER_ID + 1) % NUM_ROUTERS);
    return ROUTER_WIDTH'((ROUTER_ID + NUM_ROUTERS - 1) % NUM_ROUTERS);
  endfunction

  logic                    rsp_valid_q, rsp_valid_d;
  logic [ROUTER_WIDTH-1:0] rsp_next_q,  rsp_next_d;
  logic                    rsp_local_q, rsp_local_d;
  logic                    rsp_err_q,   rsp_err_d;
  logic [ROUTER_WIDTH-1:0] hop_sel;
  logic                    req_accept;

  assign req_ready  = !rsp_valid_q || rsp_ready;
  assign req_accept = req_valid && req_ready;

`ifdef ROUTE_TABLE_WR_EN
  logic [ROUTER_WIDTH-1:0] table_q [NUM_ROUTERS];
  logic [ROUTER_WIDTH-1:0] table_d [NUM_ROUTERS];
  logic                    wr_ok;

  // Our own entry is pinned to local delivery; out-of-range indices and
  // hops are dropped.
  assign wr_ok = cfg_wr_en
              && ({1'b0, cfg_wr_idx}  < NUM_EXT)
              && (cfg_wr_idx != SELF_ID)
              && ({1'b0, cfg_wr_next} < NUM_EXT);

  always_comb begin
    for (int i = 0; i < NUM_ROUTERS; i++) begin
      table_d[i] = table_q[i];
      if (cfg_restore)
        table_d[i] = default_hop(i);
      else if (wr_ok && (cfg_wr_idx == ROUTER_WIDTH'(i)))
        table_d[i] = cfg_wr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ROUTERS; i++) table_q[i] <= default_hop(i);
    end else begin
      for (int i = 0; i < NUM_ROUTERS; i++) table_q[i] <= table_d[i];
    end
  end

  // Reads the registered table, so a same-cycle write is not yet visible.
  always_comb begin
    hop_sel = SELF_ID;
    for (int i = 0; i < NUM_ROUTERS; i++)
      if (req_dst == ROUTER_WIDTH'(i)) hop_sel = table_q[i];
  end
`else
  // Constant table: the loop unrolls into a fixed decode of req_dst.
  always_comb begin
    hop_sel = SELF_ID;
    for (int i = 0; i < NUM_ROUTERS; i++)
      if (req_dst == ROUTER_WIDTH'(i)) hop_sel = default_hop(i);
  end

  logic unused_cfg;
  assign unused_cfg = ^{cfg_wr_en, cfg_wr_idx, cfg_wr_next, cfg_restore};
`endif

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_next_d  = rsp_next_q;
    rsp_local_d = rsp_local_q;
    rsp_err_d   = rsp_err_q;
    if (req_accept) begin
      rsp_valid_d = 1'b1;
      if ({1'b0, req_dst} >= NUM_EXT) begin
        rsp_next_d  = SELF_ID;
        rsp_local_d = 1'b0;
        rsp_err_d   = 1'b1;
      end else if (req_dst == SELF_ID) begin
        rsp_next_d  = SELF_ID;
        rsp_local_d = 1'b1;
        rsp_err_d   = 1'b0;
      end else begin
        rsp_next_d  = hop_sel;
        rsp_local_d = 1'b0;
        rsp_err_d   = 1'b0;
      end
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_next_q  <= '0;
      rsp_local_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_next_q  <= rsp_next_d;
      rsp_local_q <= rsp_local_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_next  = rsp_next_q;
  assign rsp_local = rsp_local_q;
  assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ring_route_engine.sv
// ============================================================================
// Module   : tb_ring_route_engine
// Purpose  : Self-checking bench for ring_route_engine. dut is configured
//            with 4 routers and owner 2, and dut2 with 3 routers and owner 0.
//            A transaction-level model of the routing rules predicts the
//            outputs of dut on every falling edge. Directed sections check
//            logged results against hand-computed literals. Define
//            ROUTE_TABLE_WR_EN consistently for the bench and the RTL.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ring_route_engine;

  localparam int N  = 4;
  localparam int ID = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, rsp_valid, rsp_ready, rsp_local, rsp_err;
  logic [1:0] req_dst, rsp_next;
  logic       cfg_wr_en, cfg_restore;
  logic [1:0] cfg_wr_idx, cfg_wr_next;

  logic       req_valid2, req_ready2, rsp_valid2, rsp_local2, rsp_err2;
  logic [1:0] req_dst2, rsp_next2;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int log_next[$];
  int log_local[$];
  int log_err[$];
  int log_cyc[$];

  // Model state: the output register contents expected after the next edge.
  int m_valid, m_next, m_local, m_err;
  int tbl[N];

  ring_route_engine #(.NUM_ROUTERS(N), .ROUTER_WIDTH(2), .ROUTER_ID(ID)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_dst(req_dst),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_next(rsp_next),
    .rsp_local(rsp_local), .rsp_err(rsp_err),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_next(cfg_wr_next),
    .cfg_restore(cfg_restore)
  );

  ring_route_engine #(.NUM_ROUTERS(3), .ROUTER_WIDTH(2), .ROUTER_ID(0)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_dst(req_dst2),
    .rsp_valid(rsp_valid2), .rsp_ready(1'b1), .rsp_next(rsp_next2),
    .rsp_local(rsp_local2), .rsp_err(rsp_err2),
    .cfg_wr_en(1'b0), .cfg_wr_idx(2'd0), .cfg_wr_next(2'd0),
    .cfg_restore(1'b0)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Shorter way round the ring wins; equal distances go clockwise.
  function automatic int ring_hop(input int n, input int id, input int d);
    int cw, ccw;
    if (d == id) return id;
    cw  = (d - id + n) % n;
    ccw = n - cw;
    if (cw <= ccw) return (id + 1) % n;
    return (id + n - 1) % n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_next.delete();
    log_local.delete();
    log_err.delete();
    log_cyc.delete();
  endtask

  // Compare process: check the outputs against the prediction, then predict
  // what the outputs must hold after the coming edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("reset_valid", rsp_valid, 0);
      chk("reset_next",  rsp_next,  0);
      chk("reset_local", rsp_local, 0);
      chk("reset_err",   rsp_err,   0);
      chk("reset_ready", req_ready, 1);
      for (int i = 0; i < N; i++) tbl[i] = ring_hop(N, ID, i);
      m_valid = 0; m_next = 0; m_local = 0; m_err = 0;
    end else begin
      int acc;
      int d;
      chk("valid", rsp_valid, m_valid);
      if (m_valid != 0) begin
        chk("next",  rsp_next,  m_next);
        chk("local", rsp_local, m_local);
        chk("err",   rsp_err,   m_err);
      end
      chk("ready", req_ready, ((m_valid == 0) || rsp_ready) ? 1 : 0);
      if (rsp_valid && rsp_ready) begin
        log_next.push_back(int'(rsp_next));
        log_local.push_back(int'(rsp_local));
        log_err.push_back(int'(rsp_err));
        log_cyc.push_back(cyc);
      end
      acc = (req_valid && ((m_valid == 0) || rsp_ready)) ? 1 : 0;
      d   = int'(req_dst);
      if (acc != 0) begin
        m_valid = 1;
        if (d >= N) begin
          m_next = ID; m_local = 0; m_err = 1;
        end else if (d == ID) begin
          m_next = ID; m_local = 1; m_err = 0;
        end else begin
          m_next = tbl[d]; m_local = 0; m_err = 0;
        end
      end else if (rsp_ready) begin
        m_valid = 0;
      end
`ifdef ROUTE_TABLE_WR_EN
      if (cfg_restore) begin
        for (int i = 0; i < N; i++) tbl[i] = ring_hop(N, ID, i);
      end else if (cfg_wr_en && int'(cfg_wr_idx) < N && int'(cfg_wr_idx) != ID
                   && int'(cfg_wr_next) < N) begin
        tbl[int'(cfg_wr_idx)] = int'(cfg_wr_next);
      end
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e1_next[4]  = '{3, 1, 2, 3};
    int e1_local[4] = '{0, 0, 1, 0};
    int e3_next[3];
`ifdef ROUTE_TABLE_WR_EN
    int wr_on = 1;
`else
    int wr_on = 0;
`endif
    e3_next = wr_on ? '{3, 1, 3} : '{3, 3, 3};

    rst_n = 1'b0;
    req_valid = 1'b0; req_dst = 2'd0; rsp_ready = 1'b1;
    cfg_wr_en = 1'b0; cfg_wr_idx = 2'd0; cfg_wr_next = 2'd0; cfg_restore = 1'b0;
    req_valid2 = 1'b0; req_dst2 = 2'd0;
    repeat (3) tick();

    // Four lookups back to back, the first on the first edge out of reset.
    clear_log();
    rst_n = 1'b1; req_valid = 1'b1; req_dst = 2'd0;
    tick(); req_dst = 2'd1;
    tick(); req_dst = 2'd2;
    tick(); req_dst = 2'd3;
    tick(); req_valid = 1'b0;
    tick(); tick();
    chk("b2b_count", log_next.size(), 4);
    for (int i = 0; i < 4 && i < log_next.size(); i++) begin
      chk("b2b_next",  log_next[i],  e1_next[i]);
      chk("b2b_local", log_local[i], e1_local[i]);
    end
    if (log_cyc.size() == 4) chk("b2b_consecutive", log_cyc[3] - log_cyc[0], 3);

    // Stall: result held stable and req_ready low, then release.
    clear_log();
    req_valid = 1'b1; req_dst = 2'd1; rsp_ready = 1'b0;
    tick(); req_dst = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ready", req_ready, 0);
      chk("stall_next",  rsp_next,  1);
    end
    rsp_ready = 1'b1;
    #1 chk("release_ready", req_ready, 1);
    tick(); req_valid = 1'b0;
    tick(); tick();
    chk("stall_count", log_next.size(), 2);
    if (log_next.size() == 2) begin
      chk("stall_first",  log_next[0], 1);
      chk("stall_second", log_next[1], 3);
    end

    // Same-cycle write returns the old hop, later lookups the new one.
    clear_log();
    cfg_wr_en = 1'b1; cfg_wr_idx = 2'd0; cfg_wr_next = 2'd1;
    req_valid = 1'b1; req_dst = 2'd0;
    tick(); cfg_wr_en = 1'b0;
    tick(); req_valid = 1'b0; cfg_restore = 1'b1;
    tick(); cfg_restore = 1'b0; req_valid = 1'b1;
    tick(); req_valid = 1'b0;
    tick(); tick();
    chk("wr_count", log_next.size(), 3);
    for (int i = 0; i < 3 && i < log_next.size(); i++)
      chk("wr_next", log_next[i], e3_next[i]);

    // Own-index write ignored, a legal write applied, restore beats a write.
    clear_log();
    cfg_wr_en = 1'b1; cfg_wr_idx = 2'd2; cfg_wr_next = 2'd1;
    tick(); cfg_wr_idx = 2'd1; cfg_wr_next = 2'd0;
    tick(); cfg_wr_en = 1'b0; req_valid = 1'b1; req_dst = 2'd2;
    tick(); req_dst = 2'd1;
    tick(); req_valid = 1'b0;
    cfg_restore = 1'b1; cfg_wr_en = 1'b1; cfg_wr_idx = 2'd1; cfg_wr_next = 2'd3;
    tick(); cfg_restore = 1'b0; cfg_wr_en = 1'b0; req_valid = 1'b1;
    tick(); req_valid = 1'b0;
    tick(); tick();
    chk("own_count", log_next.size(), 3);
    if (log_next.size() == 3) begin
      chk("own_local",      log_local[0], 1);
      chk("own_next",       log_next[0],  2);
      chk("legal_wr_next",  log_next[1],  wr_on ? 0 : 1);
      chk("restore_wins",   log_next[2],  1);
    end

    // A table write must not disturb a result already held.
    req_valid = 1'b1; req_dst = 2'd0; rsp_ready = 1'b0;
    tick(); req_valid = 1'b0;
    cfg_wr_en = 1'b1; cfg_wr_idx = 2'd0; cfg_wr_next = 2'd1;
    tick(); cfg_wr_en = 1'b0;
    chk("held_after_wr", rsp_next, 3);
    rsp_ready = 1'b1;
    tick(); req_valid = 1'b1;
    tick(); req_valid = 1'b0;
    #1 chk("after_held_next", rsp_next, wr_on ? 1 : 3);
    tick(); tick();

    // Reset asserted mid-stall drops the held result at once.
    req_valid = 1'b1; req_dst = 2'd1; rsp_ready = 1'b0;
    tick(); req_valid = 1'b0;
    chk("pre_reset_valid", rsp_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", rsp_valid, 0);
    chk("async_reset_next",  rsp_next,  0);
    chk("async_reset_ready", req_ready, 1);
    rsp_ready = 1'b1;
    tick(); rst_n = 1'b1;
    tick();

    // Three-router ring owned by router 0.
    req_valid2 = 1'b1; req_dst2 = 2'd3;
    tick();
    chk("r3_valid",     rsp_valid2, 1);
    chk("r3_err",       rsp_err2,   1);
    chk("r3_err_next",  rsp_next2,  0);
    chk("r3_err_local", rsp_local2, 0);
    req_dst2 = 2'd1;
    tick();
    chk("r3_dst1_next", rsp_next2, 1);
    chk("r3_dst1_err",  rsp_err2,  0);
    req_dst2 = 2'd2;
    tick();
    chk("r3_dst2_next", rsp_next2, 2);
    req_dst2 = 2'd0;
    tick();
    chk("r3_dst0_local", rsp_local2, 1);
    chk("r3_dst0_next",  rsp_next2,  0);
    req_valid2 = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
